// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle for alu_rr_arbiter: NREQ packed request slots plus one tagged result channel.
interface alu_rr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*4-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic [3:0]            rsp_flags;

    // master: requesters plus downstream consumer; slave: the arbiter
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_flags
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between NREQ requesters, one registered op in flight at a time.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = '0;
        y        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                y        = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry is the inverted borrow: 1 when a >= b unsigned
                sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                y        = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
        zero     = (y == '0);
        negative = y[WIDTH-1];
    end
endmodule

// state | meaning
// IDLE  | waiting for any req_valid; grant and latch operands on the edge
// EXEC  | ALU runs on latched operands; result captured on the edge
// RESP  | rsp_valid high, held until rsp_ready
module alu_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_rr_arbiter_if.slave   bus,
    output logic              busy
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   grant;
    logic             grant_vld;
    logic [NREQ-1:0]  req_ready_c;
    logic             accept;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_code;
    logic [IDW-1:0]   op_id;

    logic [WIDTH-1:0] rsp_y_q;
    logic [3:0]       rsp_flags_q;
    logic [IDW-1:0]   rsp_id_q;

    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             alu_v;
    logic             alu_z;
    logic             alu_n;

    assign grant_vld = |bus.req_valid;
    assign accept    = (state == IDLE) && grant_vld;

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] ptr;

    // Walk candidates from farthest to nearest after ptr so the nearest valid one wins.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        grant = '0;
        idx   = 0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (bus.req_valid[cand]) grant = cand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (accept) begin
            ptr <= grant;
        end
    end
`else
    always_comb begin
        logic [IDW-1:0] cand;
        grant = '0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'(k);
            if (bus.req_valid[cand]) grant = cand;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready_c[grant] = 1'b1;
                    state_nxt          = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            op_id       <= '0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
            rsp_id_q    <= '0;
        end else begin
            if (accept) begin
                op_a    <= bus.req_a[grant*WIDTH +: WIDTH];
                op_b    <= bus.req_b[grant*WIDTH +: WIDTH];
                op_code <= bus.req_op[grant*4 +: 4];
                op_id   <= grant;
            end
            if (state == EXEC) begin
                rsp_y_q     <= alu_y;
                rsp_flags_q <= {alu_c, alu_v, alu_z, alu_n};
                rsp_id_q    <= op_id;
            end
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .op       (op_code),
        .y        (alu_y),
        .carry    (alu_c),
        .overflow (alu_v),
        .zero     (alu_z),
        .negative (alu_n)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign busy          = (state != IDLE);
endmodule
